mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
// - Multicycle control FSM for MIPS_new. Produces count_state and the per-state datapath enables that the TB currently drives by hand.
// - Decodes opcode/funct from the instruction register.
// - Sequences IDLE->FETCH->DECODE->EXECUTE->(MEM)->WRITEBACK and loops per instruction.
// - Sits beside the datapath: instruction prep, RegFile, ALU, memory unit.
// PARAMETERS
// - STATE_WIDTH  4  width of count_state; encoding is fixed below
// - IDLE_CYCLES  1  cycles held in IDLE after reset release before the first FETCH (min 1)
// PORTS
// - clk          in   1  rising-edge clock
// - reset        in   1  asynchronous, active-low reset
// - run          in   1  1 = execute instructions; 0 = stop at the next FETCH boundary
// - opcode       in   6  IR[31:26], valid from DECODE onward
// - funct        in   6  IR[5:0], valid from DECODE onward
// - count_state  out  4  current state: IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 WRITEBACK=4 MEM=5
// - ir_write     out  1  load the instruction register
// - pc_write     out  1  PC <= PC+4
// - reg_write    out  1  RegFile write strobe
// - reg_dst      out  1  destination select: 1 = rd (R-type), 0 = rt
// - alu_src_b    out  1  ALU B operand select: 1 = sign-extended imm16, 0 = RD2
// - alu_control  out  3  ALU op: ADD=010 SUB=110 AND=000 OR=001 SLT=111
// - mem_write    out  1  data memory write strobe
// - mem_to_reg   out  1  write-back source: 1 = memory read data, 0 = ALU result
// - illegal      out  1  one-cycle pulse on an unsupported opcode/funct
// BEHAVIOUR
// Reset (reset=0, async)
// - State goes to IDLE; every output is 0 and count_state=0.
// - The async assert abandons any in-flight instruction: no write strobe may remain high.
// - The IDLE counter reloads.
// State transitions (registered, one state per clock)
// - IDLE: after IDLE_CYCLES clocks with run=1, go to FETCH. Held while run=0.
// - FETCH: ir_write=1, pc_write=1 (both exactly one cycle). Next state DECODE.
// - DECODE: latch opcode/funct into internal regs. Next state EXECUTE.
//   - A supported op is one of: R-type op=0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; addi 0x08; lw 0x23; sw 0x2B.
//   - Anything else: pulse illegal, then go to FETCH if run=1, else IDLE. No write strobes.
// - EXECUTE: alu_control/alu_src_b driven from the latched op.
//   - addi/lw/sw use ADD with imm; R-type uses funct mapping with RD2.
//   - Next state: MEM for lw/sw, else WRITEBACK.
// - MEM: sw asserts mem_write for exactly this cycle, then goes to FETCH (or IDLE if run=0). lw goes to WRITEBACK.
// - WRITEBACK: reg_write=1 for one cycle.
//   - reg_dst=1 for R-type; mem_to_reg=1 for lw.
//   - Next state FETCH if run=1, else IDLE.
// Output rules
// - Outputs are registered Moore outputs of the state plus the latched op; they are valid in the same cycle count_state shows that state.
// - alu_control/alu_src_b/reg_dst/mem_to_reg keep their EXECUTE values through MEM and WRITEBACK. They are 0 in IDLE/FETCH.
// Cycle counts and run handling
// - Latency per instruction: 4 cycles (R-type/addi), 4 (sw), 5 (lw), 3 (illegal).
// - Deasserting run mid-instruction completes the instruction; no partial commit.
// - Simultaneous run fall and WRITEBACK: WRITEBACK still writes, then goes to IDLE.
// - Unused states 6..15: recover to IDLE next clock, all outputs 0.
// - opcode/funct changes after DECODE are ignored.
// STRUCTURE
// - Shared package mips_pkg: state localparams, opcode/funct constants, alu_control codes. Datapath and TB use the same package.
// - One sub-module, mips_alu_decoder: combinational {opcode,funct} -> {alu_control, supported}. Reused by the ALU bench.
// - FSM, latches and output registers live in this module.
// TESTING
// - Reset with run=1, addi 0x21080001: count_state 0,1,2,3,4,1.
//   - ir_write/pc_write only in state 1; alu_src_b=1, alu_control=010 in 3; reg_write=1, reg_dst=0 in 4.
// - add 0x01288820: alu_control=010, alu_src_b=0, reg_dst=1, reg_write in WRITEBACK; 4 cycles FETCH-to-FETCH.
// - lw op 0x23: sequence 1,2,3,5,4; mem_to_reg=1 and reg_write=1 in 4; mem_write never high.
//   - sw op 0x2B: sequence 1,2,3,5,1; mem_write=1 only in 5; reg_write never high.
// - Opcode 0x3F: illegal=1 for one cycle, next state FETCH, no strobes.
//   - funct 0x27 with op 0: same behaviour.
// - Drop run during EXECUTE of an addi: WRITEBACK still writes, then IDLE held.
//   - Reassert run: FETCH after IDLE_CYCLES.
// - Assert reset=0 mid-MEM of a sw: mem_write drops immediately (async), count_state=0.
//   - After release: IDLE then FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS control constants, state encoding and control-word type
// Purpose: state encoding, opcode/funct constants, ALU control codes and the
//   registered control-word struct shared by the controller, datapath and benches.
// Ports: none (package).
package mips_pkg;

  localparam int STATE_WIDTH = 4;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_WRITEBACK = 4'd4,
    S_MEM       = 4'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Instruction class latched in DECODE; drives every later state.
  typedef enum logic [2:0] {
    K_RTYPE   = 3'd0,
    K_ADDI    = 3'd1,
    K_LW      = 3'd2,
    K_SW      = 3'd3,
    K_ILLEGAL = 3'd4
  } op_kind_e;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_b;
    logic [2:0] alu_control;
    logic       mem_write;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - controller <-> datapath signal bundle
// Purpose: groups run, the IR fields and all control outputs.
// Ports (master = controller side):
//   run, opcode[5:0], funct[5:0]               into the controller
//   count_state[3:0], ir_write, pc_write, reg_write, reg_dst, alu_src_b,
//   alu_control[2:0], mem_write, mem_to_reg, illegal   out of the controller
interface mips_multicycle_control_if;
  import mips_pkg::*;

  logic                   run;
  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic [STATE_WIDTH-1:0] count_state;
  logic                   ir_write;
  logic                   pc_write;
  logic                   reg_write;
  logic                   reg_dst;
  logic                   alu_src_b;
  logic [2:0]             alu_control;
  logic                   mem_write;
  logic                   mem_to_reg;
  logic                   illegal;

  modport master (
    input  run, opcode, funct,
    output count_state, ir_write, pc_write, reg_write, reg_dst, alu_src_b,
           alu_control, mem_write, mem_to_reg, illegal
  );

  modport slave (
    output run, opcode, funct,
    input  count_state, ir_write, pc_write, reg_write, reg_dst, alu_src_b,
           alu_control, mem_write, mem_to_reg, illegal
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - combinational {opcode,funct} to ALU op decoder
// Purpose: maps an instruction to its ALU operation and flags whether the
//   controller supports it.
// Ports:
//   opcode_i[5:0], funct_i[5:0]  instruction fields
//   alu_control_o[2:0]           ALU op (AND code when unsupported)
//   supported_o                  1 = instruction is executable
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       supported_o
);

  always_comb begin
    alu_control_o = ALU_AND;
    supported_o   = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        supported_o = 1'b1;
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: supported_o   = 1'b0;
        endcase
      end
      // Immediate and memory ops all compute base + imm16.
      OP_ADDI, OP_LW, OP_SW: begin
        supported_o   = 1'b1;
        alu_control_o = ALU_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM
// Purpose: sequences IDLE/FETCH/DECODE/EXECUTE/MEM/WRITEBACK and produces
//   registered Moore datapath enables.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mips_multicycle_control_if.master (run, opcode, funct in; controls out)
module mips_multicycle_control #(
  parameter int IDLE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  mips_multicycle_control_if.master   bus
);
  import mips_pkg::*;

  localparam int CNT_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  state_e          state_q, state_d;
  op_kind_e        kind_q, kind_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  ctrl_t           ctrl_q, ctrl_d;
  ctrl_t           hold;
  logic            to_boundary;

  logic [2:0]      dec_alu_control;
  logic            dec_supported;

  mips_alu_decoder u_alu_decoder (
    .opcode_i      (bus.opcode),
    .funct_i       (bus.funct),
    .alu_control_o (dec_alu_control),
    .supported_o   (dec_supported)
  );

  // Next state and next control word. Outputs are computed for the state being
  // entered so they appear in the same cycle count_state shows that state.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    idle_cnt_d  = idle_cnt_q;
    ctrl_d      = '0;
    to_boundary = 1'b0;

    // ALU/operand/write-back selects persist from EXECUTE through MEM and WRITEBACK.
    hold             = '0;
    hold.alu_control = ctrl_q.alu_control;
    hold.alu_src_b   = ctrl_q.alu_src_b;
    hold.reg_dst     = ctrl_q.reg_dst;
    hold.mem_to_reg  = ctrl_q.mem_to_reg;

    case (state_q)
      S_IDLE: begin
        if (!bus.run) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          idle_cnt_d      = '0;
          state_d         = S_FETCH;
          ctrl_d.ir_write = 1'b1;
          ctrl_d.pc_write = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_EXECUTE;
        if (!dec_supported) begin
          kind_d = K_ILLEGAL;
        end else begin
          case (bus.opcode)
            OP_RTYPE: kind_d = K_RTYPE;
            OP_ADDI:  kind_d = K_ADDI;
            OP_LW:    kind_d = K_LW;
            default:  kind_d = K_SW;
          endcase
        end
        if (kind_d == K_ILLEGAL) begin
          ctrl_d.illegal = 1'b1;
        end else begin
          ctrl_d.alu_control = dec_alu_control;
          ctrl_d.alu_src_b   = (kind_d != K_RTYPE);
          ctrl_d.reg_dst     = (kind_d == K_RTYPE);
          ctrl_d.mem_to_reg  = (kind_d == K_LW);
        end
      end
      S_EXECUTE: begin
        if (kind_q == K_ILLEGAL) begin
          to_boundary = 1'b1;
        end else if (kind_q == K_LW || kind_q == K_SW) begin
          state_d          = S_MEM;
          ctrl_d           = hold;
          ctrl_d.mem_write = (kind_q == K_SW);
        end else begin
          state_d          = S_WRITEBACK;
          ctrl_d           = hold;
          ctrl_d.reg_write = 1'b1;
        end
      end
      S_MEM: begin
        if (kind_q == K_SW) begin
          to_boundary = 1'b1;
        end else begin
          state_d          = S_WRITEBACK;
          ctrl_d           = hold;
          ctrl_d.reg_write = 1'b1;
        end
      end
      S_WRITEBACK: to_boundary = 1'b1;
      default: begin
        state_d    = S_IDLE;
        idle_cnt_d = '0;
      end
    endcase

    // Instruction boundary: run is only consulted here, so a mid-instruction
    // drop always lets the current instruction finish.
    if (to_boundary) begin
      ctrl_d     = '0;
      idle_cnt_d = '0;
      if (bus.run) begin
        state_d         = S_FETCH;
        ctrl_d.ir_write = 1'b1;
        ctrl_d.pc_write = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      kind_q     <= K_RTYPE;
      idle_cnt_q <= '0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      idle_cnt_q <= idle_cnt_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign bus.count_state = state_q;
  assign bus.ir_write    = ctrl_q.ir_write;
  assign bus.pc_write    = ctrl_q.pc_write;
  assign bus.reg_write   = ctrl_q.reg_write;
  assign bus.reg_dst     = ctrl_q.reg_dst;
  assign bus.alu_src_b   = ctrl_q.alu_src_b;
  assign bus.alu_control = ctrl_q.alu_control;
  assign bus.mem_write   = ctrl_q.mem_write;
  assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - self-checking bench for mips_multicycle_control
module tb_mips_multicycle_control;

  localparam int IDLE_CYC = 1;

  typedef struct packed {
    logic [3:0] st;
    logic       ir;
    logic       pc;
    logic       rw;
    logic       rdst;
    logic       asb;
    logic [2:0] alu;
    logic       mw;
    logic       m2r;
    logic       ill;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   instr_n = 0;
  rec_t exp_q[$];

  mips_multicycle_control_if bus();

  mips_multicycle_control #(.IDLE_CYCLES(IDLE_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  function automatic rec_t observe();
    rec_t r;
    r.st   = bus.count_state;
    r.ir   = bus.ir_write;
    r.pc   = bus.pc_write;
    r.rw   = bus.reg_write;
    r.rdst = bus.reg_dst;
    r.asb  = bus.alu_src_b;
    r.alu  = bus.alu_control;
    r.mw   = bus.mem_write;
    r.m2r  = bus.mem_to_reg;
    r.ill  = bus.illegal;
    return r;
  endfunction

  task automatic check(input string tag, input rec_t exp);
    rec_t obs;
    obs = observe();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference table: {supported, alu op} straight from the instruction set list.
  function automatic logic [3:0] ref_alu(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h08 || op == 6'h23 || op == 6'h2B) return 4'b1_010;
    if (op == 6'h00) begin
      case (fn)
        6'h20: return 4'b1_010;
        6'h22: return 4'b1_110;
        6'h24: return 4'b1_000;
        6'h25: return 4'b1_001;
        6'h2A: return 4'b1_111;
        default: return 4'b0_000;
      endcase
    end
    return 4'b0_000;
  endfunction

  // Expected per-cycle outputs of one instruction, FETCH through its last state.
  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    rec_t r;
    logic [3:0] a;
    exp_q = {};
    r = '0; r.st = 4'd1; r.ir = 1'b1; r.pc = 1'b1; exp_q.push_back(r);
    r = '0; r.st = 4'd2; exp_q.push_back(r);
    a = ref_alu(op, fn);
    r = '0; r.st = 4'd3;
    if (!a[3]) begin
      r.ill = 1'b1;
      exp_q.push_back(r);
      return;
    end
    r.alu  = a[2:0];
    r.asb  = (op != 6'h00);
    r.rdst = (op == 6'h00);
    r.m2r  = (op == 6'h23);
    exp_q.push_back(r);
    if (op == 6'h23) begin
      r.st = 4'd5; exp_q.push_back(r);
      r.st = 4'd4; r.rw = 1'b1; exp_q.push_back(r);
    end else if (op == 6'h2B) begin
      r.st = 4'd5; r.mw = 1'b1; exp_q.push_back(r);
    end else begin
      r.st = 4'd4; r.rw = 1'b1; exp_q.push_back(r);
    end
  endtask

  task automatic idle_hold(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check(tag, '0);
    end
  endtask

  // drop_at: record index after which run falls (-1 none, 99 random).
  // abort_at: record index after which reset is asserted (-1 none).
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                          input int drop_at, input int abort_at);
    int d;
    build(op, fn);
    d = (drop_at == 99) ? int'($urandom_range(0, exp_q.size() - 1)) : drop_at;
    bus.opcode = op;
    bus.funct  = fn;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      check($sformatf("instr%0d_op%h_fn%h_cyc%0d", instr_n, op, fn, i), exp_q[i]);
      if (i == 2) begin
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
      end
      if (i == d) bus.run = 1'b0;
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check("async_reset_abort", '0);
        instr_n++;
        return;
      end
    end
    instr_n++;
  endtask

  logic [5:0] fn_list [5];
  logic [5:0] op, fn;
  int         drop;

  initial begin
    fn_list = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    bus.run = 1'b1;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", '0);
    reset = 1'b1;
    #1;
    check("post_release_idle", '0);

    // Directed: addi, add, lw, sw, illegal opcode, illegal funct.
    do_instr(6'h08, 6'h01, -1, -1);
    do_instr(6'h00, 6'h20, -1, -1);
    do_instr(6'h23, 6'h04, -1, -1);
    do_instr(6'h2B, 6'h08, -1, -1);
    do_instr(6'h3F, 6'h3F, -1, -1);
    do_instr(6'h00, 6'h27, -1, -1);

    // Run drops during EXECUTE of addi: write-back completes, IDLE held.
    do_instr(6'h08, 6'h01, 2, -1);
    idle_hold(3, "run_low_idle");
    bus.run = 1'b1;
    idle_hold(IDLE_CYC - 1, "rerun_idle");
    do_instr(6'h00, 6'h2A, -1, -1);

    // Reset asserted during MEM of sw.
    do_instr(6'h2B, 6'h00, -1, 3);
    reset = 1'b1;
    #1;
    check("after_abort_idle", '0);
    idle_hold(IDLE_CYC - 1, "after_abort_idle_wait");

    // Randomized instruction stream with occasional run drops.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: begin op = 6'h00; fn = fn_list[$urandom_range(0, 4)]; end
        1: begin op = 6'h08; fn = 6'($urandom); end
        2: begin op = 6'h23; fn = 6'($urandom); end
        3: begin op = 6'h2B; fn = 6'($urandom); end
        4: begin op = 6'h00; fn = 6'($urandom); end
        default: begin op = 6'($urandom); fn = 6'($urandom); end
      endcase
      drop = ($urandom_range(0, 4) == 0) ? 99 : -1;
      do_instr(op, fn, drop, -1);
      if (drop == 99) begin
        idle_hold(int'($urandom_range(1, 3)), "rand_run_low_idle");
        bus.run = 1'b1;
        idle_hold(IDLE_CYC - 1, "rand_rerun_idle");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
